// File: rtl/fpnew_arb_pkg.sv
// Shared helpers for the opgroup request arbiter: id field width and round-robin pointer advance.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fpnew_arb_pkg;

  localparam int PERF_CNT_W = 32;

  // A single requester still carries a 1-bit id so the tag layout never collapses to zero width.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Pointer moves to the requester just after the one granted, wrapping at num_req.
  function automatic int rr_next(input int idx, input int num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpnew_arb_outstanding_cnt.sv
// Per-requester in-flight operation counter with limit flag.
// Latency: count updates 1 cycle after the inc/dec/clr event; flags come from registered state.
// Backpressure: at_limit_o blocks further grants to this requester until a response retires.
module fpnew_arb_outstanding_cnt #(
  parameter int MaxOutstanding = 4,
  parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic at_limit_o,
  output logic nz_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, a simultaneous issue and retire cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A response for a requester with nothing outstanding means a corrupted tag downstream.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i && dec_i && !inc_i) begin
      assert (cnt_q != '0);
    end
  end

  assign at_limit_o = (cnt_q == CntW'(MaxOutstanding));
  assign nz_o       = |cnt_q;

endmodule

// File: rtl/fpnew_opgroup_req_arbiter.sv
// Round-robin sharing of one FPU opgroup block among NumReq requesters; id carried in the downstream tag.
// Latency: 1 cycle request->issue (registered), 0 cycles response->requester (combinational demux).
// Backpressure: issue register holds while fpu_ready_i=0; per-requester outstanding limit; response
//   ready follows the addressed requester. Optional perf counters under FPNEW_ARB_PERF_CNT_EN.
module fpnew_opgroup_req_arbiter import fpnew_arb_pkg::*; #(
  parameter int NumReq         = 4,
  parameter int ReqWidth       = 128,
  parameter int RspWidth       = 38,
  parameter int TagWidth       = 8,
  parameter int MaxOutstanding = 4,
  localparam int IdW           = id_width(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*ReqWidth-1:0]   req_data_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         fpu_valid_o,
  input  logic                         fpu_ready_i,
  output logic [ReqWidth-1:0]          fpu_data_o,
  output logic [IdW+TagWidth-1:0]      fpu_tag_o,
  output logic                         fpu_flush_o,
  input  logic                         fpu_rsp_valid_i,
  output logic                         fpu_rsp_ready_o,
  input  logic [RspWidth-1:0]          fpu_rsp_data_i,
  input  logic [IdW+TagWidth-1:0]      fpu_rsp_tag_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [RspWidth-1:0]          rsp_data_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  output logic                         busy_o
`ifdef FPNEW_ARB_PERF_CNT_EN
  ,
  output logic [NumReq*PERF_CNT_W-1:0] perf_grant_cnt_o,
  output logic [NumReq*PERF_CNT_W-1:0] perf_stall_cnt_o
`endif
);

  logic [NumReq-1:0]       elig, at_limit, cnt_nz, req_hs, rsp_hs;
  logic [IdW-1:0]          rr_q, rr_d, grant_idx, rsp_id;
  logic                    grant_vld, can_issue, issue_hs, rsp_id_ok;
  logic                    fpu_valid_q, fpu_valid_d;
  logic [ReqWidth-1:0]     fpu_data_q, fpu_data_d;
  logic [IdW+TagWidth-1:0] fpu_tag_q, fpu_tag_d;

  assign elig = req_valid_i & ~at_limit;

  // First eligible requester at or after the rr pointer, wrapping around.
  always_comb begin
    int             idx;
    logic [IdW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx  = (int'(rr_q) + k) % NumReq;
      cand = IdW'(idx);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Register can take a new op when empty or draining; nothing is accepted while flushing.
  assign can_issue = (~fpu_valid_q | fpu_ready_i) & ~flush_i;
  assign issue_hs  = can_issue & grant_vld;

  // Ready goes only to the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (issue_hs) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign req_hs = req_valid_i & req_ready_o;

  // Issue register and rr pointer next state: flush empties, accept loads, handshake drains.
  always_comb begin
    fpu_valid_d = fpu_valid_q;
    fpu_data_d  = fpu_data_q;
    fpu_tag_d   = fpu_tag_q;
    rr_d        = rr_q;
    if (flush_i) begin
      fpu_valid_d = 1'b0;
    end else if (issue_hs) begin
      fpu_valid_d = 1'b1;
      fpu_data_d  = req_data_i[int'(grant_idx)*ReqWidth +: ReqWidth];
      fpu_tag_d   = {grant_idx, req_tag_i[int'(grant_idx)*TagWidth +: TagWidth]};
      rr_d        = IdW'(rr_next(int'(grant_idx), NumReq));
    end else if (fpu_ready_i) begin
      fpu_valid_d = 1'b0;
    end
  end

  // Issue register and rr pointer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpu_valid_q <= 1'b0;
      fpu_data_q  <= '0;
      fpu_tag_q   <= '0;
      rr_q        <= '0;
    end else begin
      fpu_valid_q <= fpu_valid_d;
      fpu_data_q  <= fpu_data_d;
      fpu_tag_q   <= fpu_tag_d;
      rr_q        <= rr_d;
    end
  end

  assign fpu_valid_o = fpu_valid_q;
  assign fpu_data_o  = fpu_data_q;
  assign fpu_tag_o   = fpu_tag_q;
  assign fpu_flush_o = flush_i;

  // Response demux: ids with no requester behind them, and anything during flush, are swallowed.
  assign rsp_id    = fpu_rsp_tag_i[TagWidth +: IdW];
  assign rsp_id_ok = ({1'b0, rsp_id} < (IdW+1)'(NumReq));

  always_comb begin
    rsp_valid_o     = '0;
    fpu_rsp_ready_o = 1'b1;
    if (!flush_i && rsp_id_ok) begin
      rsp_valid_o[rsp_id] = fpu_rsp_valid_i;
      fpu_rsp_ready_o     = rsp_ready_i[rsp_id];
    end
  end

  assign rsp_data_o = fpu_rsp_data_i;
  assign rsp_tag_o  = fpu_rsp_tag_i[TagWidth-1:0];
  assign rsp_hs     = rsp_valid_o & rsp_ready_i;

  for (genvar g = 0; g < NumReq; g++) begin : g_cnt
    fpnew_arb_outstanding_cnt #(
      .MaxOutstanding (MaxOutstanding)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (flush_i),
      .inc_i      (req_hs[g]),
      .dec_i      (rsp_hs[g]),
      .at_limit_o (at_limit[g]),
      .nz_o       (cnt_nz[g])
    );
  end

  assign busy_o = fpu_valid_q | (|cnt_nz);

`ifdef FPNEW_ARB_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] PerfMax = '1;

  logic [NumReq*PERF_CNT_W-1:0] perf_grant_q, perf_stall_q;

  // Saturating accept/stall counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_hs[i] && perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] != PerfMax) begin
          perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] <= perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
        end
        if (req_valid_i[i] && !req_ready_o[i] &&
            perf_stall_q[i*PERF_CNT_W +: PERF_CNT_W] != PerfMax) begin
          perf_stall_q[i*PERF_CNT_W +: PERF_CNT_W] <= perf_stall_q[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
        end
      end
    end
  end

  assign perf_grant_cnt_o = perf_grant_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpnew_opgroup_req_arbiter.sv
// Scoreboarded bench for the opgroup request arbiter (NumReq=4, MaxOutstanding=2).
// Expected issues/responses are queued by the stimulus and retired by a negedge monitor.
// Inputs change 1 time unit after posedge; everything is sampled on negedge.
module tb_fpnew_opgroup_req_arbiter;

  localparam int NR = 4;
  localparam int RW = 128;
  localparam int SW = 38;
  localparam int TW = 8;
  localparam int MO = 2;
  localparam int IW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*RW-1:0]  req_data_i;
  logic [NR*TW-1:0]  req_tag_i;
  logic              fpu_valid_o;
  logic              fpu_ready_i;
  logic [RW-1:0]     fpu_data_o;
  logic [IW+TW-1:0]  fpu_tag_o;
  logic              fpu_flush_o;
  logic              fpu_rsp_valid_i;
  logic              fpu_rsp_ready_o;
  logic [SW-1:0]     fpu_rsp_data_i;
  logic [IW+TW-1:0]  fpu_rsp_tag_i;
  logic [NR-1:0]     rsp_valid_o;
  logic [NR-1:0]     rsp_ready_i;
  logic [SW-1:0]     rsp_data_o;
  logic [TW-1:0]     rsp_tag_o;
  logic              busy_o;

  fpnew_opgroup_req_arbiter #(
    .NumReq         (NR),
    .ReqWidth       (RW),
    .RspWidth       (SW),
    .TagWidth       (TW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_data_i      (req_data_i),
    .req_tag_i       (req_tag_i),
    .fpu_valid_o     (fpu_valid_o),
    .fpu_ready_i     (fpu_ready_i),
    .fpu_data_o      (fpu_data_o),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_flush_o     (fpu_flush_o),
    .fpu_rsp_valid_i (fpu_rsp_valid_i),
    .fpu_rsp_ready_o (fpu_rsp_ready_o),
    .fpu_rsp_data_i  (fpu_rsp_data_i),
    .fpu_rsp_tag_i   (fpu_rsp_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_data_o      (rsp_data_o),
    .rsp_tag_o       (rsp_tag_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IW+TW-1:0] tag;
    logic [RW-1:0]    data;
  } iss_t;

  typedef struct packed {
    logic [NR-1:0] vld;
    logic [TW-1:0] tag;
    logic [SW-1:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] dat(input int i, input int n);
    logic [63:0] hi, lo;
    hi = 64'hFEED_0000_0000_0000 + 64'(n);
    lo = 64'hC0DE_0000_0000_0000 + 64'(i);
    return {hi, lo};
  endfunction

  task automatic drive_req(input int i, input logic [TW-1:0] t, input logic [RW-1:0] d);
    req_tag_i[i*TW +: TW]  = t;
    req_data_i[i*RW +: RW] = d;
  endtask

  task automatic expect_iss(input int i, input logic [TW-1:0] t, input logic [RW-1:0] d);
    iss_t e;
    e.tag  = {IW'(i), t};
    e.data = d;
    iss_q.push_back(e);
  endtask

  task automatic drive_rsp(input int i, input logic [TW-1:0] t, input logic [SW-1:0] d);
    rsp_t e;
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = {IW'(i), t};
    fpu_rsp_data_i  = d;
    e.vld  = NR'(1) << i;
    e.tag  = t;
    e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    flush_i         = 1'b0;
    req_valid_i     = '0;
    fpu_rsp_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_busy", busy_o, 0);
    chk("reset_fpu_valid", fpu_valid_o, 0);
    step();
  endtask

  // Monitor: retire expected issues and responses on every handshake.
  always @(negedge clk_i) begin : mon
    iss_t e;
    rsp_t r;
    if (!rst_i) begin
      if (fpu_valid_o && fpu_ready_i) begin
        if (iss_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_issue: got tag %0h expected none", fpu_tag_o);
        end else begin
          e = iss_q.pop_front();
          chk("issue_tag", fpu_tag_o, e.tag);
          chk("issue_data", fpu_data_o, e.data);
        end
      end
      if (|(rsp_valid_o & rsp_ready_i)) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got valid %0h expected none", rsp_valid_o);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_route", rsp_valid_o, r.vld);
          chk("rsp_tag", rsp_tag_o, r.tag);
          chk("rsp_data", rsp_data_o, r.data);
          chk("rsp_fpu_ready", fpu_rsp_ready_o, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin : stim
    rst_i           = 1'b1;
    flush_i         = 1'b0;
    req_valid_i     = '0;
    req_data_i      = '0;
    req_tag_i       = '0;
    fpu_ready_i     = 1'b0;
    fpu_rsp_valid_i = 1'b0;
    fpu_rsp_data_i  = '0;
    fpu_rsp_tag_i   = '0;
    rsp_ready_i     = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_fpu_valid", fpu_valid_o, 0);
    chk("rst_fpu_data", fpu_data_o, 0);
    chk("rst_fpu_tag", fpu_tag_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_flush_out", fpu_flush_o, 0);
    step();

    // T1: all valid, downstream always ready -> 0,1,2,3,0
    fpu_ready_i = 1'b1;
    rsp_ready_i = '1;
    for (int i = 0; i < NR; i++) drive_req(i, TW'(8'h10 + i), dat(i, 1));
    req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NR;
      @(negedge clk_i);
      chk($sformatf("t1_grant%0d", k), req_ready_o, NR'(1) << g);
      expect_iss(g, TW'(8'h10 + g), dat(g, 1));
      step();
    end
    req_valid_i = '0;
    @(negedge clk_i);
    chk("t1_busy", busy_o, 1);
    chk("t1_idle_ready", req_ready_o, 0);
    step();
    step();
    do_reset();

    // T2: outstanding limit of 2 on req0, reopened by one response
    fpu_ready_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      drive_req(0, TW'(8'h20 + k), dat(0, 2 + k));
      @(negedge clk_i);
      chk($sformatf("t2_accept%0d", k), req_ready_o, 4'b0001);
      expect_iss(0, TW'(8'h20 + k), dat(0, 2 + k));
      step();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk($sformatf("t2_limit%0d", k), req_ready_o, 0);
      step();
    end
    drive_rsp(0, 8'h20, 38'h1_0000_0020);
    @(negedge clk_i);
    chk("t2_limit_at_rsp", req_ready_o, 0);
    step();
    fpu_rsp_valid_i = 1'b0;
    drive_req(0, 8'h22, dat(0, 4));
    @(negedge clk_i);
    chk("t2_reopen", req_ready_o, 4'b0001);
    expect_iss(0, 8'h22, dat(0, 4));
    step();
    req_valid_i = '0;
    step();
    step();
    do_reset();

    // T3: downstream stalls 5 cycles with the issue register full
    fpu_ready_i = 1'b0;
    drive_req(1, 8'h31, dat(1, 3));
    drive_req(2, 8'h32, dat(2, 3));
    req_valid_i = 4'b0110;
    @(negedge clk_i);
    chk("t3_grant1", req_ready_o, 4'b0010);
    expect_iss(1, 8'h31, dat(1, 3));
    step();
    drive_req(1, 8'h3F, dat(1, 9));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk($sformatf("t3_valid%0d", k), fpu_valid_o, 1);
      chk($sformatf("t3_tag%0d", k), fpu_tag_o, {2'd1, 8'h31});
      chk($sformatf("t3_data%0d", k), fpu_data_o, dat(1, 3));
      chk($sformatf("t3_ready%0d", k), req_ready_o, 0);
      chk($sformatf("t3_busy%0d", k), busy_o, 1);
      step();
    end
    fpu_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t3_grant2", req_ready_o, 4'b0100);
    expect_iss(2, 8'h32, dat(2, 3));
    step();
    req_valid_i = '0;
    step();

    // T4: response to id2 held by its requester, then id0 routed after it
    drive_req(0, 8'h40, dat(0, 4));
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    chk("t4_grant0_wrap", req_ready_o, 4'b0001);
    expect_iss(0, 8'h40, dat(0, 4));
    step();
    req_valid_i = '0;
    rsp_ready_i = 4'b1011;
    drive_rsp(2, 8'h32, 38'h2_2222_2222);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("t4_hold_vld%0d", k), rsp_valid_o, 4'b0100);
      chk($sformatf("t4_hold_rdy%0d", k), fpu_rsp_ready_o, 0);
      chk($sformatf("t4_hold_tag%0d", k), rsp_tag_o, 8'h32);
      step();
    end
    rsp_ready_i = 4'hF;
    step();
    drive_rsp(0, 8'h40, 38'h0_4040_4040);
    step();
    fpu_rsp_valid_i = 1'b0;

    // T5: accept and retire on req1 in the same cycle keeps its count at 1
    drive_req(1, 8'h51, dat(1, 5));
    req_valid_i = 4'b0010;
    drive_rsp(1, 8'h31, 38'h1_5151_5151);
    @(negedge clk_i);
    chk("t5_both", req_ready_o, 4'b0010);
    expect_iss(1, 8'h51, dat(1, 5));
    step();
    fpu_rsp_valid_i = 1'b0;
    drive_req(1, 8'h52, dat(1, 6));
    @(negedge clk_i);
    chk("t5_cnt_one", req_ready_o, 4'b0010);
    expect_iss(1, 8'h52, dat(1, 6));
    step();
    @(negedge clk_i);
    chk("t5_cnt_two", req_ready_o, 0);
    step();
    req_valid_i = '0;

    // T6: flush with counts {1,2,0,1} and the issue register full
    drive_req(0, 8'h60, dat(0, 6));
    drive_req(3, 8'h63, dat(3, 6));
    req_valid_i = 4'b1001;
    @(negedge clk_i);
    chk("t6_grant3", req_ready_o, 4'b1000);
    expect_iss(3, 8'h63, dat(3, 6));
    step();
    @(negedge clk_i);
    chk("t6_grant0", req_ready_o, 4'b0001);
    // No expectation queued for req0's op: the flush below kills it in the register.
    step();
    req_valid_i = '0;
    fpu_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t6_full", fpu_valid_o, 1);
    chk("t6_busy", busy_o, 1);
    step();
    flush_i     = 1'b1;
    req_valid_i = 4'hF;
    drive_req(1, 8'h61, dat(1, 7));
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = {2'd1, 8'h51};
    rsp_ready_i     = '0;
    @(negedge clk_i);
    chk("t6_flush_req_ready", req_ready_o, 0);
    chk("t6_flush_rsp_ready", fpu_rsp_ready_o, 1);
    chk("t6_flush_rsp_valid", rsp_valid_o, 0);
    chk("t6_flush_out", fpu_flush_o, 1);
    step();
    flush_i         = 1'b0;
    req_valid_i     = '0;
    fpu_rsp_valid_i = 1'b0;
    rsp_ready_i     = '1;
    @(negedge clk_i);
    chk("t6_post_valid", fpu_valid_o, 0);
    chk("t6_post_busy", busy_o, 0);
    step();
    fpu_ready_i = 1'b1;
    req_valid_i = 4'hF;
    @(negedge clk_i);
    chk("t6_rr_kept", req_ready_o, 4'b0010);
    expect_iss(1, 8'h61, dat(1, 7));
    step();
    req_valid_i = '0;
    repeat (3) step();

    chk("iss_q_drained", iss_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
